// File: rtl/mem_arb_rr_if.sv
// Bundle of the request, grant and memory-controller signals between the cores,
// the arbiter and the memory controller. The arbiter takes the slave modport.
interface mem_arb_rr_if #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned IdW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0]        req_rd;
  logic [N_PORTS-1:0]        req_wr;
  logic [N_PORTS*ADDR_W-1:0] req_addr;
  logic [N_PORTS*DATA_W-1:0] req_wd;
  logic [N_PORTS-1:0]        port_stall;
  logic                      mem_busy;
  logic                      mem_we;
  logic                      mem_re;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wd;
  logic                      grant_valid;
  logic [IdW-1:0]            grant_id;
  logic                      proto_err;

  modport master (
    output req_rd, req_wr, req_addr, req_wd, mem_busy,
    input  port_stall, mem_we, mem_re, mem_addr, mem_wd, grant_valid, grant_id, proto_err
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_wd, mem_busy,
    output port_stall, mem_we, mem_re, mem_addr, mem_wd, grant_valid, grant_id, proto_err
  );
endinterface

// File: rtl/mem_arb_rr.sv
// Multi-core memory arbiter: one grant at a time, round-robin or fixed priority,
// with a single arbitration cycle before each access and no preemption.
module mem_arb_rr #(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_MODE = 0
) (
  input logic         clk,
  input logic         rst_n,
  mem_arb_rr_if.slave bus
);
  localparam int unsigned IdW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StOwned = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [IdW-1:0]     grant_q, grant_d;
  logic [IdW-1:0]     last_q, last_d;
  logic               perr_q, perr_d;

  logic [N_PORTS-1:0] req;
  logic               owned;
  logic               g_rd, g_wr, g_req;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wd;
  logic               accept;
  logic               win_found;
  logic [IdW-1:0]     win_id;

  assign req   = bus.req_rd | bus.req_wr;
  assign owned = (state_q == StOwned);

  // Mux of the currently granted port; meaningful only while owned.
  always_comb begin
    g_rd   = 1'b0;
    g_wr   = 1'b0;
    g_addr = '0;
    g_wd   = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (grant_q == IdW'(i)) begin
        g_rd   = bus.req_rd[i];
        g_wr   = bus.req_wr[i];
        g_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        g_wd   = bus.req_wd[i*DATA_W +: DATA_W];
      end
    end
  end

  assign g_req  = g_rd | g_wr;
  assign accept = owned & g_req & ~bus.mem_busy;

  // Winner selection. Round-robin walks distance 1..N_PORTS from the last accepted port.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    if (PRIO_MODE == 1) begin
      for (int i = int'(N_PORTS) - 1; i >= 0; i--) begin
        if (req[i]) begin
          win_found = 1'b1;
          win_id    = IdW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= int'(N_PORTS); k++) begin
        for (int i = 0; i < int'(N_PORTS); i++) begin
          if (!win_found && req[i] && (i == (int'(last_q) + k) % int'(N_PORTS))) begin
            win_found = 1'b1;
            win_id    = IdW'(i);
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    perr_d  = perr_q | (owned & g_rd & g_wr);
    if (state_q == StIdle) begin
      if (win_found) begin
        state_d = StOwned;
        grant_d = win_id;
      end
    end else begin
      if (accept) begin
        state_d = StIdle;
        last_d  = grant_q;
      end else if (!g_req) begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdW'(N_PORTS - 1);
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    bus.port_stall = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      bus.port_stall[i] = req[i] & ~(owned & (grant_q == IdW'(i)) & ~bus.mem_busy);
    end
  end

  // A write wins when both strobes are requested together.
  assign bus.mem_we      = owned & g_wr;
  assign bus.mem_re      = owned & g_rd & ~g_wr;
  assign bus.mem_addr    = g_addr;
  assign bus.mem_wd      = g_wd;
  assign bus.grant_valid = owned;
  assign bus.grant_id    = grant_q;
  assign bus.proto_err   = perr_q;
endmodule
